lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store control unit sitting directly downstream of the instruction decoder. It consumes the decoder's `dmem_access` code, the ALU-computed address and the store data. It runs a request/grant/response handshake with a word-organised data memory that may stall, and returns a sign- or zero-extended load result with a one-cycle `done` pulse. Misaligned and unknown access codes are reported as errors and never reach memory.

## Interface
Parameters:
- `MISALIGN_CHECK`, default 1: 1 = misaligned half/word accesses raise `err`; 0 = low address bits are ignored for alignment.

Ports:
- `clk` input 1: the single clock.
- `rstn` input 1: reset, asynchronous, active-low.
- `start` input 1: accepted only in IDLE; latches `access`, `addr`, `wdata`.
- `access` input 4: decoder `dmem_access` code (inst[25:22]).
  - 0000 LD_B, 0001 LD_H, 0010 LD_W, 1000 LD_BU, 1001 LD_HU.
  - 0100 ST_B, 0101 ST_H, 0110 ST_W.
  - Any other code is invalid.
- `addr` input 32: byte address from the ALU.
- `wdata` input 32: store source register value.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: valid with `done`; 1 = misaligned or invalid code.
- `rdata` output 32: extended load result, valid with `done`, held until the next `done`.
- `mem_req` output 1: memory request.
- `mem_we` output 1: 1 = write.
- `mem_addr` output 32: word address, {addr[31:2], 2'b00}.
- `mem_wstrb` output 4: byte write enables.
- `mem_wdata` output 32: store data shifted to the addressed byte lane.
- `mem_gnt` input 1: request accepted this cycle.
- `mem_rvalid` input 1: read data valid.
- `mem_rdata` input 32: read word.

## Operation
The unit is a state machine with states IDLE, REQ, WAIT, DONE.

- IDLE:
  - On `start`, register `access`, `addr` and `wdata`, and compute `bad`.
  - `bad` is set for an invalid code, or when `MISALIGN_CHECK` is 1 and either a half access has addr[0]=1 or a word access has addr[1:0]≠0.
  - If `bad`, go to DONE with `err`=1. Otherwise go to REQ.
- REQ:
  - `mem_req`=1. `mem_we`=1 for stores. `mem_addr`, `mem_wstrb` and `mem_wdata` come from the latched values and stay stable until grant.
  - On `mem_gnt`: a store goes to DONE; a load goes to WAIT.
- WAIT:
  - `mem_req`=0.
  - On `mem_rvalid`, select the byte or half using latched addr[1:0], extend it, load `rdata`, and go to DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.
- Store lanes:
  - ST_B: `mem_wstrb` = 0001 << addr[1:0]; `mem_wdata` = {4{wdata[7:0]}}.
  - ST_H: `mem_wstrb` = 0011 << {addr[1],1'b0}; `mem_wdata` = {2{wdata[15:0]}}.
  - ST_W: `mem_wstrb` = 1111; `mem_wdata` = `wdata`.
- Load extension:
  - LD_B and LD_H sign-extend.
  - LD_BU and LD_HU zero-extend.
  - LD_W passes the word through unchanged.
- `mem_wstrb` = 0000 and `mem_we` = 0 whenever `mem_req` = 0.
- On an error, `rdata` is left unchanged.

## Timing
- Reset (`rstn`=0, asynchronous):
  - State goes to IDLE.
  - `busy`, `done`, `err`, `mem_req`, `mem_we` = 0.
  - `mem_wstrb` = 0, `mem_addr`, `mem_wdata` and `rdata` = 0.
  - Reset asserted mid-transaction abandons it, with no `done`. Memory must tolerate a dropped request.
- All outputs are registered or decoded from the registered state and latches. There is no combinational path from `start` to `mem_*`.
- Minimum latency, counting `start` in cycle 0:
  - Store: REQ in cycle 1 with `mem_gnt`=1, `done` in cycle 2.
  - Load: REQ in cycle 1 with grant, `mem_rvalid` in cycle 2, `done` in cycle 3.
  - Error: `done`+`err` in cycle 1.
- `mem_gnt` low holds REQ indefinitely with the request held. `mem_rvalid` low holds WAIT. There is no timeout.
- `mem_rvalid` seen in REQ or IDLE is ignored.
- `start` during `busy` is ignored, not queued. `start` in the same cycle as DONE is also ignored. A new `start` is accepted in IDLE, so `done` is never back-to-back.
- `access` and `addr` are don't-care outside the `start` cycle.

## Test plan
- Reset: drive `rstn` low mid-REQ. Required: all outputs 0 and state IDLE the same cycle. After release, a LD_W to 0x100 completes normally.
- LD_B addr 0x103 with `mem_rdata`=0x80FF_1234. Required: `rdata`=0xFFFF_FF80, `err`=0, `done` in cycle 3. Repeat as LD_BU. Required: `rdata`=0x0000_0080.
- ST_H addr 0x202, wdata=0xDEAD_BEEF, `mem_gnt` held low for 3 cycles. Required: during REQ, `mem_req`=1, `mem_addr`=0x200, `mem_wstrb`=1100 and `mem_wdata`=0xBEEF_BEEF, all stable for the 4 cycles; `done` one cycle after grant.
- LD_W addr 0x101. Required: `done`=1 and `err`=1 in cycle 1, `mem_req` never asserted, `rdata` unchanged. Access code 0011 gives the same response.
- With `MISALIGN_CHECK`=0, LD_H addr 0x201 and `mem_rdata`=0x1234_8765. Required: `rdata`=0xFFFF_8765 (half selected by addr[1]=0), `err`=0.
- Pulse `start` every cycle during a load with `mem_rvalid` delayed 5 cycles. Required: exactly one transaction, one `done`, `busy` high from cycle 1 until DONE.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control between decoder and word-organised dmem.
// Ports: start/access/addr/wdata in; busy/done/err/rdata out; mem_* req/gnt/rvalid bus.
module lsu_ctrl #(
  parameter bit MISALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [3:0]  access,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_WAIT, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  acc_q, acc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        in_ld, in_st, bad, mis;
  logic        st_q;
  logic [31:0] sh;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] ld_val;

  // classify the incoming code on the start cycle
  always_comb begin
    in_ld = 1'b0;
    in_st = 1'b0;
    unique case (access)
      4'b0000, 4'b0001, 4'b0010,
      4'b1000, 4'b1001: in_ld = 1'b1;
      4'b0100, 4'b0101, 4'b0110: in_st = 1'b1;
      default: ;
    endcase
    mis = ((access[1:0] == 2'd1) && addr[0])
       || ((access[1:0] == 2'd2) && (addr[1:0] != 2'd0));
    bad = !(in_ld || in_st) || (MISALIGN_CHECK && mis);
  end

  // valid loads have bit 2 clear, valid stores have it set
  assign st_q = acc_q[2];

  // lane select and extension of the returned word
  always_comb begin
    sh   = mem_rdata >> {addr_q[1:0], 3'b000};
    bsel = sh[7:0];
    hsel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (acc_q[1:0])
      2'd0: ld_val = acc_q[3] ? {24'd0, bsel}
                              : {{24{bsel[7]}}, bsel};
      2'd1: ld_val = acc_q[3] ? {16'd0, hsel}
                              : {{16{hsel[15]}}, hsel};
      default: ld_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = access;
          addr_d  = addr;
          wdata_d = wdata;
          err_d   = bad;
          state_d = bad ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt) state_d = st_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = ld_val;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      acc_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // outputs decoded from state and latches only
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    err       = done && err_q;
    rdata     = rdata_q;
    mem_req   = (state_q == S_REQ);
    mem_we    = mem_req && st_q;
    mem_addr  = {addr_q[31:2], 2'b00};
    mem_wstrb = 4'b0000;
    unique case (acc_q[1:0])
      2'd0:    mem_wdata = {4{wdata_q[7:0]}};
      2'd1:    mem_wdata = {2{wdata_q[15:0]}};
      default: mem_wdata = wdata_q;
    endcase
    if (mem_we) begin
      unique case (acc_q[1:0])
        2'd0:    mem_wstrb = 4'b0001 << addr_q[1:0];
        2'd1:    mem_wstrb = 4'b0011 << {addr_q[1], 1'b0};
        default: mem_wstrb = 4'b1111;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl.
// Second instance runs with misalignment checking disabled.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [3:0]  access;
  logic [31:0] addr, wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        u0_busy, u0_done, u0_err, u0_req, u0_we;
  logic [31:0] u0_rdata, u0_addr, u0_wdata;
  logic [3:0]  u0_wstrb;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt, req_cnt;

  always #5 clk = ~clk;

  lsu_ctrl u_dut (
    .clk(clk), .rstn(rstn), .start(start), .access(access),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .err(err), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  lsu_ctrl #(.MISALIGN_CHECK(1'b0)) u_dut0 (
    .clk(clk), .rstn(rstn), .start(start), .access(access),
    .addr(addr), .wdata(wdata), .busy(u0_busy), .done(u0_done),
    .err(u0_err), .rdata(u0_rdata), .mem_req(u0_req),
    .mem_we(u0_we), .mem_addr(u0_addr), .mem_wstrb(u0_wstrb),
    .mem_wdata(u0_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start in cycle 0, grant in 1, rvalid in 2; returns in cycle 3
  task automatic do_load(input logic [3:0] a,
                         input logic [31:0] ad,
                         input logic [31:0] rd);
    start = 1'b1; access = a; addr = ad;
    tick();
    start = 1'b0; mem_gnt = 1'b1;
    check("ld_req_c1", {31'd0, u0_req}, 32'd1);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd;
    check("ld_req_c2", {31'd0, u0_req}, 32'd0);
    check("ld_done_c2", {31'd0, u0_done}, 32'd0);
    tick();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; access = 4'd0; addr = 32'd0;
    wdata = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 32'd0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rstn = 1'b1;
    tick();

    // reset asserted mid-REQ
    start = 1'b1; access = 4'b0010; addr = 32'h100;
    tick();
    start = 1'b0;
    check("mid_req", {31'd0, mem_req}, 32'd1);
    check("mid_busy", {31'd0, busy}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_req", {31'd0, mem_req}, 32'd0);
    check("arst_addr", mem_addr, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    #2 rstn = 1'b1;
    tick();
    do_load(4'b0010, 32'h100, 32'hCAFE_BABE);
    check("ldw_done", {31'd0, done}, 32'd1);
    check("ldw_err", {31'd0, err}, 32'd0);
    check("ldw_rdata", rdata, 32'hCAFE_BABE);
    tick();
    check("ldw_idle", {31'd0, busy}, 32'd0);

    // LD_B / LD_BU from byte lane 3
    do_load(4'b0000, 32'h103, 32'h80FF_1234);
    check("ldb_done", {31'd0, done}, 32'd1);
    check("ldb_err", {31'd0, err}, 32'd0);
    check("ldb_rdata", rdata, 32'hFFFF_FF80);
    tick();
    check("ldb_done_off", {31'd0, done}, 32'd0);
    do_load(4'b1000, 32'h103, 32'h80FF_1234);
    check("ldbu_done", {31'd0, done}, 32'd1);
    check("ldbu_rdata", rdata, 32'h0000_0080);
    tick();

    // ST_H with grant stalled 3 cycles
    start = 1'b1; access = 4'b0101; addr = 32'h202;
    wdata = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      mem_gnt = (c == 4);
      check("sth_req", {31'd0, mem_req}, 32'd1);
      check("sth_we", {31'd0, mem_we}, 32'd1);
      check("sth_addr", mem_addr, 32'h200);
      check("sth_wstrb", {28'd0, mem_wstrb}, 32'hC);
      check("sth_wdata", mem_wdata, 32'hBEEF_BEEF);
      check("sth_done0", {31'd0, done}, 32'd0);
      tick();
    end
    mem_gnt = 1'b0;
    check("sth_done", {31'd0, done}, 32'd1);
    check("sth_err", {31'd0, err}, 32'd0);
    check("sth_req_off", {31'd0, mem_req}, 32'd0);
    check("sth_wstrb_off", {28'd0, mem_wstrb}, 32'd0);
    tick();
    check("sth_we_idle", {31'd0, mem_we}, 32'd0);

    // misaligned LD_W: error on checked unit, plain load on u_dut0
    start = 1'b1; access = 4'b0010; addr = 32'h101;
    tick();
    start = 1'b0; mem_gnt = 1'b1;
    check("mis_done", {31'd0, done}, 32'd1);
    check("mis_err", {31'd0, err}, 32'd1);
    check("mis_req", {31'd0, mem_req}, 32'd0);
    check("mis_rdata", rdata, 32'h0000_0080);
    check("mis0_req", {31'd0, u0_req}, 32'd1);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    check("mis_idle_req", {31'd0, mem_req}, 32'd0);
    tick();
    mem_rvalid = 1'b0;
    check("mis_rdata_hold", rdata, 32'h0000_0080);
    check("mis0_rdata", u0_rdata, 32'h5555_AAAA);
    check("mis0_done", {31'd0, u0_done}, 32'd1);
    tick();

    // invalid code 0011
    start = 1'b1; access = 4'b0011; addr = 32'h100;
    tick();
    start = 1'b0;
    check("bad_done", {31'd0, done}, 32'd1);
    check("bad_err", {31'd0, err}, 32'd1);
    check("bad_req", {31'd0, mem_req}, 32'd0);
    check("bad0_err", {31'd0, u0_err}, 32'd1);
    tick();

    // misalignment ignored on u_dut0: LD_H 0x201 takes low half
    do_load(4'b0001, 32'h201, 32'h1234_8765);
    check("nochk_done", {31'd0, u0_done}, 32'd1);
    check("nochk_err", {31'd0, u0_err}, 32'd0);
    check("nochk_rdata", u0_rdata, 32'hFFFF_8765);
    check("chk_rdata_hold", rdata, 32'h0000_0080);
    tick();

    // start held high through a load with delayed rvalid
    start = 1'b1; access = 4'b0010; addr = 32'h100;
    done_cnt = 0; req_cnt = 0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 9) start = 1'b0;
      mem_gnt = (c == 1);
      mem_rvalid = (c == 7);
      mem_rdata = 32'h1122_3344;
      if (done) done_cnt++;
      if (mem_req) req_cnt++;
      check("spam_busy", {31'd0, busy}, {31'd0, c <= 8});
      check("spam_done", {31'd0, done}, {31'd0, c == 8});
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check("spam_ndone", done_cnt, 32'd1);
    check("spam_nreq", req_cnt, 32'd1);
    check("spam_rdata", rdata, 32'h1122_3344);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
